ram_be_sync: RTL and testbench

Parametrised single-port synchronous RAM for the RV32 core's instruction and data memories. It adds four things to the basic read/write array:
- per-byte write enables;
- a valid/ready request port with a response strobe;
- a selectable read-during-write mode and an optional output register;
- a hardware clear sequencer that zeroes the whole array after reset.

It sits between the core's load/store unit (or fetch unit) and the storage array, and replaces direct array instantiation.

---
 rtl/ram_be_sync_if.sv | 24 ++
 rtl/ram_be_sync.sv | 70 +++++++
 tb/tb_ram_be_sync.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ram_be_sync_if.sv
// ram_be_sync_if: request/response bus of the byte-enable RAM
interface ram_be_sync_if #(
  parameter int Width = 32,
  parameter int Depth = 10
);
  localparam int Lanes = Width / 8;
  logic             req_valid;
  logic             req_ready;
  logic [Depth-1:0] req_addr;
  logic             req_we;
  logic [Lanes-1:0] req_be;
  logic [Width-1:0] req_wdata;
  logic             rsp_valid;
  logic [Width-1:0] rsp_rdata;
  logic             busy;
  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );
  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/ram_be_sync.sv
// ram_be_sync: single-port RAM with byte enables, valid/ready port and post-reset clear
module ram_be_sync #(
  parameter int Width        = 32,
  parameter int Depth        = 10,
  parameter int OutReg       = 0,
  parameter int RdMode       = 0,
  parameter int ClearOnReset = 1
) (
  input logic          clk,
  input logic          rst_n,
  ram_be_sync_if.slave bus
);
  localparam int Lanes = Width / 8;
  typedef enum logic {CLEAR, READY} state_t;
  state_t           state;
  logic [Depth-1:0] cnt;
  logic [Width-1:0] mem [2**Depth];
  logic [Width-1:0] old, merged, data;
  logic             acc;
  assign bus.req_ready = rst_n && state == READY;
  assign bus.busy = rst_n ? state == CLEAR : ClearOnReset != 0;
  assign acc = bus.req_valid && bus.req_ready;
  assign old = mem[bus.req_addr];
  always_comb begin
    merged = old;
    for (int i = 0; i < Lanes; i++)
      if (bus.req_be[i]) merged[8*i +: 8] = bus.req_wdata[8*i +: 8];
  end
  assign data = bus.req_we && RdMode != 0 ? merged : old;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ClearOnReset != 0 ? CLEAR : READY;
      cnt   <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (&cnt) state <= READY;
    end
  end
  always_ff @(posedge clk) begin
    if (rst_n && state == CLEAR) mem[cnt] <= '0;
    else if (acc && bus.req_we) mem[bus.req_addr] <= merged;
  end
  if (OutReg != 0) begin : g_oreg
    logic             v1;
    logic [Width-1:0] d1;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v1            <= 1'b0;
        d1            <= '0;
        bus.rsp_valid <= 1'b0;
        bus.rsp_rdata <= '0;
      end else begin
        v1            <= acc;
        d1            <= acc ? data : d1;
        bus.rsp_valid <= v1;
        bus.rsp_rdata <= v1 ? d1 : bus.rsp_rdata;
      end
    end
  end else begin : g_direct
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        bus.rsp_valid <= 1'b0;
        bus.rsp_rdata <= '0;
      end else begin
        bus.rsp_valid <= acc;
        bus.rsp_rdata <= acc ? data : bus.rsp_rdata;
      end
    end
  end
endmodule

// File: tb/tb_ram_be_sync.sv
// tb_ram_be_sync: three RAM configurations driven in lockstep against a scoreboard model
module tb_ram_be_sync;
  localparam int N = 3;
  typedef struct {
    logic [31:0] d;
    bit          dc;
    int          c;
  } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic valid = 1'b0, we = 1'b0;
  logic [3:0] addr = '0, be = '0;
  logic [31:0] wdata = '0;
  always #5 clk = ~clk;

  int outreg[N] = '{0, 1, 1};
  int rdmode[N] = '{0, 1, 0};
  int clr[N]    = '{1, 1, 0};

  logic        rv[N], rdy[N], bsy[N];
  logic [31:0] rd[N];
  logic [31:0] mem[N][16];
  bit          known[N][16];
  exp_t        q[N][$];
  int cyc = 0, total = 0, bad = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < N; g++) begin : gi
    ram_be_sync_if #(.Width(32), .Depth(4)) b ();
    ram_be_sync #(.Width(32), .Depth(4), .OutReg(g == 0 ? 0 : 1), .RdMode(g == 1 ? 1 : 0),
                  .ClearOnReset(g == 2 ? 0 : 1)) u (.clk(clk), .rst_n(rst_n), .bus(b));
    assign b.req_valid = valid;
    assign b.req_we    = we;
    assign b.req_addr  = addr;
    assign b.req_be    = be;
    assign b.req_wdata = wdata;
    assign rv[g]  = b.rsp_valid;
    assign rd[g]  = b.rsp_rdata;
    assign rdy[g] = b.req_ready;
    assign bsy[g] = b.busy;
    always @(negedge clk) begin
      exp_t e;
      while (q[g].size() > 0 && q[g][0].c < cyc) begin
        total++;
        bad++;
        $display("FAIL missing_rsp%0d: got none want %h due cycle %0d", g, q[g][0].d, q[g][0].c);
        void'(q[g].pop_front());
      end
      if (rv[g]) begin
        if (q[g].size() == 0) check($sformatf("unexpected_rsp%0d", g), 32'd1, 32'd0);
        else begin
          e = q[g].pop_front();
          check($sformatf("rsp_cycle%0d", g), cyc, e.c);
          if (!e.dc) check($sformatf("rsp_data%0d", g), rd[g], e.d);
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [3:0] a, input logic [3:0] b, input logic [31:0] d);
    logic [31:0] o, n;
    bit k, nk;
    exp_t e;
    for (int i = 0; i < N; i++) check($sformatf("ready%0d", i), 32'(rdy[i]), 32'd1);
    valid = 1'b1; we = w; addr = a; be = b; wdata = d;
    for (int i = 0; i < N; i++) begin
      o = mem[i][a];
      k = known[i][a];
      n = o;
      for (int l = 0; l < 4; l++) if (b[l]) n[8*l +: 8] = d[8*l +: 8];
      nk = k || b == 4'hF;
      if (w) begin
        mem[i][a] = n;
        known[i][a] = nk;
      end
      e.d  = (w && rdmode[i] != 0) ? n : o;
      e.dc = !((w && rdmode[i] != 0) ? nk : k);
      e.c  = cyc + 1 + outreg[i];
      q[i].push_back(e);
    end
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      while (q[i].size() > 0 && q[i][q[i].size()-1].c >= cyc) void'(q[i].pop_back());
    repeat (cycles - 1) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_rsp_valid%0d", i), 32'(rv[i]), 32'd0);
      check($sformatf("rst_rsp_rdata%0d", i), rd[i], 32'd0);
      check($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd0);
      check($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'(clr[i]));
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rel_ready%0d", i), 32'(rdy[i]), 32'(clr[i] == 0));
      check($sformatf("rel_busy%0d", i), 32'(bsy[i]), 32'(clr[i]));
    end
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!(rdy[0] && rdy[1] && rdy[2]) && n < 100) begin
      @(posedge clk);
      n++;
      #1;
    end
    check(name, n, 32'd16);
    for (int i = 0; i < N; i++) check($sformatf("%s_busy%0d", name, i), 32'(bsy[i]), 32'd0);
    for (int i = 0; i < N; i++)
      if (clr[i] != 0)
        for (int a = 0; a < 16; a++) begin
          mem[i][a] = '0;
          known[i][a] = 1'b1;
        end
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] v;
    do_reset(3);
    wait_ready("clear_len");
    do_reset(2);
    repeat (7) @(posedge clk);
    @(negedge clk);
    do_reset(1);
    wait_ready("clear_restart");
    for (int a = 0; a < 16; a++) issue(1'b0, 4'(a), 4'h0, 32'h0);
    issue(1'b1, 4'd3, 4'b0101, 32'hAABBCCDD);
    issue(1'b0, 4'd3, 4'h0, 32'h0);
    issue(1'b1, 4'd3, 4'b0000, 32'h11223344);
    issue(1'b0, 4'd3, 4'hF, 32'h0);
    issue(1'b1, 4'd5, 4'hF, 32'h11111111);
    issue(1'b1, 4'd5, 4'b0011, 32'h22222222);
    issue(1'b1, 4'd1, 4'hF, 32'hA1);
    issue(1'b1, 4'd2, 4'hF, 32'hA2);
    issue(1'b1, 4'd3, 4'hF, 32'hA3);
    for (int a = 1; a < 4; a++) issue(1'b0, 4'(a), 4'h0, 32'h0);
    for (int t = 0; t < 400; t++)
      if ($urandom_range(3) == 0) @(negedge clk);
      else issue(1'($urandom), 4'($urandom), 4'($urandom), $urandom);
    repeat (4) @(negedge clk);
    v = $urandom;
    issue(1'b1, 4'd9, 4'hF, v);
    issue(1'b0, 4'd9, 4'h0, 32'h0);
    do_reset(1);
    wait_ready("clear_after_op");
    issue(1'b0, 4'd9, 4'h0, 32'h0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < N; i++) check($sformatf("drain%0d", i), q[i].size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end
endmodule
